// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: handshake codes, command bits and status bit positions for usb_ep_ring
package usb_ep_pkg;
    typedef enum logic [1:0] {
        HS_ACK   = 2'b00,
        HS_NONE  = 2'b01,
        HS_NAK   = 2'b10,
        HS_STALL = 2'b11
    } hs_e;

    localparam int CMD_COMMIT    = 0;
    localparam int CMD_RELEASE   = 1;
    localparam int CMD_CLR_SETUP = 2;
    localparam int CMD_STALL     = 3;
    localparam int CMD_TOG1      = 4;
    localparam int CMD_TOG0      = 5;

    localparam int ST_TOGGLE  = 7;
    localparam int ST_STALL   = 6;
    localparam int ST_FULL    = 5;
    localparam int ST_SETUP   = 5;
    localparam int ST_EMPTY   = 4;
    localparam int ST_OVERRUN = 4;
endpackage

// File: rtl/usb_ep_ring_ptr.sv
// usb_ep_ring_ptr: ring write/read pointers and fill level; flush with push loads one entry at bank 0
module usb_ep_ring_ptr #(
    parameter int BANKS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    output logic [$clog2(BANKS)-1:0]  wr,
    output logic [$clog2(BANKS)-1:0]  rd,
    output logic [$clog2(BANKS):0]    fill,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = $clog2(BANKS);
    localparam int FW = PW + 1;

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        wr_d    = flush ? PW'(push) : wr_q + PW'(push_ok);
        rd_d    = flush ? '0 : rd_q + PW'(pop_ok);
        fill_d  = flush ? FW'(push) : fill_q + FW'(push_ok) - FW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
        end
    end

    assign wr    = wr_q;
    assign rd    = rd_q;
    assign fill  = fill_q;
    assign full  = fill_q == FW'(BANKS);
    assign empty = fill_q == '0;
endmodule

// File: rtl/usb_ep_ring.sv
// usb_ep_ring: multi-bank USB endpoint with IN/OUT buffer rings; `USB_EP_ISO_EN adds the iso port
module usb_ep_ring
    import usb_ep_pkg::*;
#(
    parameter int BANKS = 2,
    parameter int CNT_W = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      direction_in,
    input  logic                      setup,
    input  logic                      success,
    input  logic [CNT_W-1:0]          cnt,
    output logic                      toggle,
    output logic [$clog2(BANKS)-1:0]  bank_usb,
    output logic [1:0]                handshake,
    output logic [$clog2(BANKS)-1:0]  bank_in,
    output logic [$clog2(BANKS)-1:0]  bank_out,
    output logic                      in_data_valid,
    input  logic                      ctrl_dir_in,
    output logic [15:0]               ctrl_rd_data,
    input  logic [15:0]               ctrl_wr_data,
`ifdef USB_EP_ISO_EN
    input  logic                      iso,
`endif
    input  logic [1:0]                ctrl_wr_en
);
    localparam int PW = $clog2(BANKS);
    localparam int FW = PW + 1;

    logic             iso_w;
`ifdef USB_EP_ISO_EN
    assign iso_w = iso;
`else
    assign iso_w = 1'b0;
`endif

    logic [7:0]       cmd;
    logic             cmd_in, cmd_out, cflush_in, cflush_out, setup_ok, in_ok, out_ok;
    logic             push_i, pop_i, flush_i, push_o, pop_o, flush_o;
    logic [PW-1:0]    wr_i, rd_i, wr_o, rd_o;
    logic [FW-1:0]    fill_i, fill_o;
    logic             full_i, empty_i, full_o, empty_o;
    logic             tog_in_q, tog_in_d, tog_out_q, tog_out_d;
    logic             stall_in_q, stall_in_d, stall_out_q, stall_out_d;
    logic             ep_setup_q, ep_setup_d, overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_in_q [BANKS];
    logic [CNT_W-1:0] cnt_in_d [BANKS];
    logic [CNT_W-1:0] cnt_out_q [BANKS];
    logic [CNT_W-1:0] cnt_out_d [BANKS];
    logic [CNT_W-1:0] in_cnt;
    logic [7:0]       st;
    logic             unused_ok;

    assign cmd       = ctrl_wr_data[7:0];
    assign unused_ok = ^{ctrl_wr_data, empty_o};

    // SETUP beats every OUT command except clearing ep_setup
    always_comb begin
        cmd_in     = ctrl_wr_en[0] & ctrl_dir_in;
        cmd_out    = ctrl_wr_en[0] & ~ctrl_dir_in;
        cflush_in  = cmd_in & |cmd[CMD_TOG0:CMD_STALL];
        cflush_out = cmd_out & |cmd[CMD_TOG0:CMD_STALL];
        setup_ok   = success & ~direction_in & setup;
        in_ok      = success & direction_in;
        out_ok     = success & ~direction_in & ~setup;
        flush_i    = setup_ok | cflush_in;
        push_i     = cmd_in & cmd[CMD_COMMIT] & ~flush_i;
        pop_i      = in_ok;
        flush_o    = setup_ok | cflush_out;
        push_o     = setup_ok | (out_ok & ~full_o & ~cflush_out);
        pop_o      = cmd_out & cmd[CMD_RELEASE];
        tog_in_d   = setup_ok ? 1'b1 : (cmd_in & cmd[CMD_TOG0]) ? 1'b0 : (cmd_in & cmd[CMD_TOG1]) ? 1'b1 :
                     (in_ok & ~empty_i & ~cflush_in) ? ~tog_in_q : tog_in_q;
        tog_out_d  = setup_ok ? 1'b1 : (cmd_out & cmd[CMD_TOG0]) ? 1'b0 : (cmd_out & cmd[CMD_TOG1]) ? 1'b1 :
                     (out_ok & ~full_o & ~cflush_out) ? ~tog_out_q : tog_out_q;
        stall_in_d = (cmd_in & cmd[CMD_STALL]) ? 1'b1 : (cmd_in & (cmd[CMD_TOG0] | cmd[CMD_TOG1])) ? 1'b0 : stall_in_q;
        stall_out_d = setup_ok ? stall_out_q : (cmd_out & cmd[CMD_STALL]) ? 1'b1 :
                      (cmd_out & (cmd[CMD_TOG0] | cmd[CMD_TOG1])) ? 1'b0 : stall_out_q;
        ep_setup_d = (cmd_out & cmd[CMD_CLR_SETUP]) ? 1'b0 : setup_ok ? 1'b1 : ep_setup_q;
        overrun_d  = flush_o ? 1'b0 : (iso_w & out_ok & full_o) ? 1'b1 : overrun_q;
        cnt_in_d   = cnt_in_q;
        if (ctrl_wr_en[1] & ctrl_dir_in)
            cnt_in_d[wr_i] = ctrl_wr_data[8 +: CNT_W];
        cnt_out_d  = cnt_out_q;
        if (push_o)
            cnt_out_d[setup_ok ? PW'(0) : wr_o] = cnt;
    end

    usb_ep_ring_ptr #(.BANKS(BANKS)) u_in (
        .clk(clk), .rst_n(rst_n), .push(push_i), .pop(pop_i), .flush(flush_i),
        .wr(wr_i), .rd(rd_i), .fill(fill_i), .full(full_i), .empty(empty_i)
    );

    usb_ep_ring_ptr #(.BANKS(BANKS)) u_out (
        .clk(clk), .rst_n(rst_n), .push(push_o), .pop(pop_o), .flush(flush_o),
        .wr(wr_o), .rd(rd_o), .fill(fill_o), .full(full_o), .empty(empty_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog_in_q    <= 1'b0;
            tog_out_q   <= 1'b0;
            stall_in_q  <= 1'b0;
            stall_out_q <= 1'b0;
            ep_setup_q  <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_in_q    <= '{default: '0};
            cnt_out_q   <= '{default: '0};
        end else begin
            tog_in_q    <= tog_in_d;
            tog_out_q   <= tog_out_d;
            stall_in_q  <= stall_in_d;
            stall_out_q <= stall_out_d;
            ep_setup_q  <= ep_setup_d;
            overrun_q   <= overrun_d;
            cnt_in_q    <= cnt_in_d;
            cnt_out_q   <= cnt_out_d;
        end
    end

    // an empty iso IN ring sends a zero-length packet
    always_comb begin
        in_cnt        = (iso_w & empty_i) ? '0 : cnt_in_q[rd_i];
        in_data_valid = cnt != in_cnt;
        toggle        = ~iso_w & (direction_in ? tog_in_q : (~setup & tog_out_q));
        bank_usb      = direction_in ? rd_i : wr_o;
        bank_in       = wr_i;
        bank_out      = rd_o;
        handshake     = iso_w ? HS_NONE :
                        direction_in ? (ep_setup_q ? HS_NAK : stall_in_q ? HS_STALL : empty_i ? HS_NAK : HS_ACK) :
                        (setup ? HS_ACK : ep_setup_q ? HS_NAK : stall_out_q ? HS_STALL : full_o ? HS_NAK : HS_ACK);
        st            = '0;
        st[3:0]       = 4'(ctrl_dir_in ? fill_i : fill_o);
        st[ST_TOGGLE] = ctrl_dir_in ? tog_in_q : tog_out_q;
        st[ST_STALL]  = ctrl_dir_in ? stall_in_q : stall_out_q;
        st[ST_FULL]   = ctrl_dir_in ? full_i : ep_setup_q;
        st[ST_EMPTY]  = ctrl_dir_in ? empty_i : overrun_q;
        ctrl_rd_data  = {8'(ctrl_dir_in ? cnt_in_q[wr_i] : cnt_out_q[rd_o]), st};
    end
endmodule

// File: doc/usb_ep_ring.md
# usb_ep_ring

Parametrised multi-bank USB endpoint controller; successor to the fixed double-buffered endpoint. It holds a ring of `BANKS` buffers per direction, with independent data toggles and per-bank IN byte counts. It sits between the USB protocol engine (transaction side) and the CPU control bus (register side), and supplies bank indices to the shared packet RAM.

## Interface
- `BANKS`, 2: banks per direction; power of two, 2..8.
- `CNT_W`, 7: packet byte-count width; 1..8.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `direction_in` in 1: current transaction is IN.
- `setup` in 1: current OUT transaction is SETUP.
- `success` in 1: one-cycle pulse, transaction completed with ACK.
- `cnt` in CNT_W: bytes moved in current transaction.
- `toggle` out 1: expected/sent DATA0/1.
- `bank_usb` out $clog2(BANKS): RAM bank used by the USB side.
- `handshake` out 2: ack=00, none=01, nak=10, stall=11.
- `bank_in` out $clog2(BANKS): IN bank the CPU is filling.
- `bank_out` out $clog2(BANKS): oldest filled OUT bank for the CPU.
- `in_data_valid` out 1: `cnt` is not equal to the count of the IN bank being sent.
- `ctrl_dir_in` in 1: register access targets the IN side.
- `ctrl_rd_data` out 16: status read.
- `ctrl_wr_data` in 16: command/count write.
- `ctrl_wr_en` in 2: [1] count byte, [0] command byte.
- `iso` in 1: present only with `USB_EP_ISO_EN`.

## Operation
- Each direction has a write pointer, a read pointer and a fill level (0..BANKS, $clog2(BANKS)+1 bits). Pointers wrap modulo BANKS.
- IN side:
  - CPU writes the count with `ctrl_wr_en[1]`; `ctrl_wr_data[8+:CNT_W]` goes to `bank_in`.
  - Commit (cmd bit0): if not full, fill+1 and `bank_in`+1; if full, ignored.
  - IN `success`: read pointer+1, fill-1, toggle inverts.
  - `bank_usb` = IN read pointer when `direction_in`.
- OUT side:
  - `bank_usb` = OUT write pointer when not `direction_in`.
  - OUT `success` with fill<BANKS: store `cnt` for that bank, write pointer+1, fill+1, toggle inverts.
  - Release (cmd bit1): if not empty, fill-1 and `bank_out`+1.
- SETUP `success`:
  - Flush both rings; data lands in OUT bank 0; OUT fill=1.
  - Set `ep_setup`; both toggles set to 1.
- Command byte (`ctrl_wr_en[0]`, side selected by `ctrl_dir_in`):
  - [5]: toggle=0, stall=0, flush.
  - [4]: toggle=1, stall=0, flush.
  - [3]: stall=1, flush.
  - [2]: clear `ep_setup` (OUT only).
  - [1]: release (OUT only).
  - [0]: commit (IN only).
  - Flush: that side's pointers and fill go to 0.
- `toggle`:
  - 0 if OUT and `setup`.
  - Otherwise the toggle of the selected direction.
- `handshake`, IN: ack if fill>0, not stalled and not `ep_setup`; stall if stalled and not `ep_setup`; otherwise nak.
- `handshake`, OUT:
  - ack if `setup`, or if fill<BANKS, not stalled and not `ep_setup`.
  - stall if stalled and not `ep_setup`.
  - otherwise nak.
- `ctrl_rd_data[15:8]`: zero-extended count, of `bank_in` (IN side) or `bank_out` (OUT side).
- `ctrl_rd_data[7:0]`, IN: {toggle, stall, full, empty, fill[3:0]}.
- `ctrl_rd_data[7:0]`, OUT: {toggle, stall, ep_setup, overrun, fill[3:0]}. Fill is zero-extended to 4 bits.

## Timing
- All outputs are combinational from state; updates become visible the cycle after the triggering edge.
- Reset (`rst_n`=0 at edge): pointers, fills, counts, toggles, stalls, `ep_setup` and overrun all go to 0.
- Resulting outputs after reset:
  - `toggle` 0.
  - `bank_*` 0.
  - IN `handshake` nak; OUT `handshake` ack.
  - `in_data_valid` = (`cnt`!=0).
- Reset has priority over everything and aborts any in-flight transaction state.
- `success` together with a commit or release in the same cycle: both pointers move; fill is unchanged.
- `success` together with a stall or flush command on the same side: the command wins; pointers, fill and toggle take the command values.
- SETUP `success` together with an OUT command: SETUP wins, except that bit2 still clears `ep_setup` if set in the same cycle.

## Configuration
- `USB_EP_ISO_EN` defined: adds `iso` port. When `iso`=1:
  - `handshake` = none.
  - `toggle` = 0.
  - Stall is ignored.
  - OUT `success` when full drops the packet and sets sticky overrun, cleared by flush.
  - IN when empty: `bank_usb` still points at the read pointer and the bank count reads 0, so a zero-length packet is sent; success while empty leaves state unchanged.
- Undefined: no `iso` port; the overrun bit reads 0.

## Structure
- Package `usb_ep_pkg`: handshake codes, command bit indices, status bit positions.
- Sub-module `usb_ep_ring_ptr`: write/read pointer and fill counter with push/pop/flush. Instantiated once per direction.

## Test plan
- Reset, BANKS=4: IN handshake=10, OUT handshake=00, all `bank_*`=0.
- Commit 4 IN banks with counts 8,16,24,32: 5th commit ignored; four IN successes return `bank_usb` 0,1,2,3 and `toggle` 0,1,0,1; fill ends at 0.
- Four OUT successes with no release: 5th transaction gets nak; a release sets `bank_out`=1 and the next OUT gets ack.
- SETUP success with 2 IN banks pending: IN fill=0, OUT fill=1, both toggles=1, IN handshake nak until cmd bit2.
- Commit and IN success in the same cycle at fill=2: fill stays 2 and both pointers advance.
- `USB_EP_ISO_EN`, `iso`=1, OUT full plus success: handshake 01, overrun=1, fill unchanged.
